// File: rtl/button_pkg.sv
// Shared definitions for the button/LED controller slice.
//   btn_state_t    : per-channel debounce FSM states
//   MODE_MOMENTARY : LED follows the debounced button level
//   MODE_TOGGLE    : LED flips on every accepted press
//   BTN_PRESSED    : raw/synchronised level meaning "button pressed"
package button_pkg;

  typedef enum logic [1:0] {
    S_RELEASED    = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_PRESSED     = 2'd2,
    S_RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam logic MODE_MOMENTARY = 1'b0;
  localparam logic MODE_TOGGLE    = 1'b1;
  localparam logic BTN_PRESSED    = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter and 4-state FSM.
// A level change is accepted after DEBOUNCE_CYC consecutive stable
// synchronised samples.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   button         : raw asynchronous button level
//   pressed_q      : debounced level (S_PRESSED or S_RELEASE_CHK)
//   press_pulse    : registered one-cycle pulse per accepted press
//   release_pulse  : registered one-cycle pulse per accepted release
//   press_evt      : combinational, high when press_pulse sets on this edge
//   release_evt    : combinational, high when release_pulse sets on this edge
module btn_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic pressed_q,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_evt,
  output logic release_evt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_ff;
  logic             sync_hi;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

  assign sync_hi = (sync_ff[1] == BTN_PRESSED);

  // Events are exposed one edge early so the top can update toggle bit and
  // LED on the same edge that registers the pulse.
  always_comb begin
    press_evt   = (state == S_PRESS_CHK)   &&  sync_hi && (cnt == CNT_LAST);
    release_evt = (state == S_RELEASE_CHK) && !sync_hi && (cnt == CNT_LAST);
    pressed_q   = (state == S_PRESSED) || (state == S_RELEASE_CHK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff       <= '0;
      state         <= S_RELEASED;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_ff       <= {sync_ff[0], button};
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      case (state)
        S_RELEASED: begin
          if (sync_hi) begin
            state <= S_PRESS_CHK;
            cnt   <= CNT_ONE;
          end
        end
        S_PRESS_CHK: begin
          if (!sync_hi) begin
            state <= S_RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_PRESSED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_PRESSED: begin
          if (!sync_hi) begin
            state <= S_RELEASE_CHK;
            cnt   <= CNT_ONE;
          end
        end
        S_RELEASE_CHK: begin
          if (sync_hi) begin
            state <= S_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_RELEASED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_led_ctrl.sv
// Multi-channel button/LED controller. Each channel debounces its button,
// emits press/release pulses and drives an LED in momentary or toggle mode.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   button[N_CH]   : raw asynchronous button levels, 1 = pressed
//   mode[N_CH]     : 0 = momentary, 1 = toggle (per channel, run time)
//   led[N_CH]      : registered LED drive, 1 = on
//   press_pulse    : one-cycle pulse per accepted press
//   release_pulse  : one-cycle pulse per accepted release
module button_led_ctrl
  import button_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  input  logic [N_CH-1:0] mode,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse
);

  logic [N_CH-1:0] pressed_q;
  logic [N_CH-1:0] press_evt;
  logic [N_CH-1:0] release_evt;
  logic [N_CH-1:0] pressed_next;
  logic [N_CH-1:0] t_q;
  logic [N_CH-1:0] t_next;
  logic [N_CH-1:0] led_next;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb (
      .clk           (clk),
      .reset         (reset),
      .button        (button[i]),
      .pressed_q     (pressed_q[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .press_evt     (press_evt[i]),
      .release_evt   (release_evt[i])
    );

    // Debounced level as it will be after this edge.
    assign pressed_next[i] = press_evt[i] | (pressed_q[i] & ~release_evt[i]);
    assign t_next[i]       = t_q[i] ^ press_evt[i];
    assign led_next[i]     = (mode[i] == MODE_TOGGLE) ? t_next[i] : pressed_next[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_q <= '0;
      led <= '0;
    end else begin
      t_q <= t_next;
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_button_led_ctrl.sv
module tb_button_led_ctrl;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] button;
  logic [N-1:0] mode;
  logic [N-1:0] led;
  logic [N-1:0] pp;
  logic [N-1:0] rp;

  always #5 clk = ~clk;

  button_led_ctrl #(
    .N_CH         (N),
    .DEBOUNCE_CYC (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .button        (button),
    .mode          (mode),
    .led           (led),
    .press_pulse   (pp),
    .release_pulse (rp)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: raw button reaches the debouncer two edges later; the
  // accepted level flips once DEBOUNCE_CYC consecutive samples disagree.
  logic [N-1:0] d1, d2, lvl, t, mp, mr, mled;
  int           run [N];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_edge(input logic r, input logic [N-1:0] b, input logic [N-1:0] m);
    if (r) begin
      d1 = '0; d2 = '0; lvl = '0; t = '0; mp = '0; mr = '0; mled = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      mp = '0; mr = '0;
      for (int i = 0; i < N; i++) begin
        if (d2[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == D) begin
            lvl[i] = d2[i];
            run[i] = 0;
            if (d2[i]) begin
              mp[i] = 1'b1;
              t[i]  = ~t[i];
            end else begin
              mr[i] = 1'b1;
            end
          end
        end else begin
          run[i] = 0;
        end
      end
      d2 = d1;
      d1 = b;
      for (int i = 0; i < N; i++) mled[i] = m[i] ? t[i] : lvl[i];
    end
  endtask

  task automatic apply(input logic r, input logic [N-1:0] b, input logic [N-1:0] m);
    @(negedge clk);
    reset  = r;
    button = b;
    mode   = m;
    @(posedge clk);
    model_edge(r, b, m);
    #1;
    check("model", 16'({led, pp, rp}), 16'({mled, mp, mr}));
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] b;
    logic [N-1:0] m;
    logic [N-1:0] el;
    logic [N-1:0] ep;
    logic [N-1:0] er;
  } vec_t;

  vec_t         tbl[$];
  vec_t         v;
  logic         seen;
  int           npulse;
  int           k_hit;
  logic [N-1:0] pv;
  logic [N-1:0] rb;
  logic [N-1:0] rm;
  logic         rr;

  initial begin
    reset = 1'b1; button = '0; mode = '0;
    apply(1'b1, '0, '0);
    apply(1'b1, '0, '0);
    check("reset_state", 16'({led, pp, rp}), 16'h0);

    // Idle rows, then a clean momentary press/release on channel 0.
    for (int i = 0; i < 10; i++) begin
      v = '{r: 1'b0, b: '0, m: '0, el: '0, ep: '0, er: '0};
      tbl.push_back(v);
    end
    for (int k = 0; k < 30; k++) begin
      v.r  = 1'b0;
      v.m  = '0;
      v.b  = (k < 20) ? 4'b0001 : 4'b0000;
      v.el = (k >= 5 && k < 25) ? 4'b0001 : 4'b0000;
      v.ep = (k == 5) ? 4'b0001 : 4'b0000;
      v.er = (k == 25) ? 4'b0001 : 4'b0000;
      tbl.push_back(v);
    end
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].b, tbl[i].m);
      check("table", 16'({led, pp, rp}), 16'({tbl[i].el, tbl[i].ep, tbl[i].er}));
    end

    // Short high glitch on channel 1.
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin apply(1'b0, 4'b0010, '0); seen |= pp[1]; end
    for (int i = 0; i < 8; i++) begin apply(1'b0, 4'b0000, '0); seen |= pp[1]; end
    check("glitch_no_press", 16'(seen), 16'h0);
    check("glitch_led", 16'(led[1]), 16'h0);

    // Two-cycle low dip while channel 1 is held.
    for (int i = 0; i < 10; i++) apply(1'b0, 4'b0010, '0);
    check("dip_pressed", 16'(led[1]), 16'h1);
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin apply(1'b0, 4'b0000, '0); seen |= rp[1]; end
    for (int i = 0; i < 8; i++) begin apply(1'b0, 4'b0010, '0); seen |= rp[1]; end
    check("dip_no_release", 16'(seen), 16'h0);
    check("dip_led", 16'(led[1]), 16'h1);
    for (int i = 0; i < 8; i++) apply(1'b0, 4'b0000, '0);

    // Toggle mode on channel 2: three presses give 1, 0, 1.
    for (int p = 0; p < 3; p++) begin
      npulse = 0;
      for (int i = 0; i < 8; i++) begin
        apply(1'b0, 4'b0100, 4'b0100);
        if (pp[2]) begin
          npulse++;
          check("toggle_led_at_pulse", 16'(led[2]), 16'((p % 2) == 0));
        end
      end
      check("toggle_pulse_count", 16'(npulse), 16'h1);
      for (int i = 0; i < 8; i++) apply(1'b0, 4'b0000, 4'b0100);
      check("toggle_release_keeps", 16'(led[2]), 16'((p % 2) == 0));
    end

    // Simultaneous press on channels 0 and 3, then mode switch on 3.
    pv = '0;
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 4'b1001, 4'b1000);
      if (pp != '0 && pv == '0) pv = pp;
    end
    check("simul_pulses", 16'(pv), 16'h9);
    check("toggle_led3", 16'(led[3]), 16'h1);
    for (int i = 0; i < 2; i++) apply(1'b0, 4'b1001, 4'b0000);
    check("mode_switch_led3", 16'(led[3]), 16'h1);
    for (int i = 0; i < 8; i++) apply(1'b0, 4'b0000, 4'b0000);
    check("release_led3", 16'(led[3]), 16'h0);

    // Reset while channel 0 is mid-debounce (cnt == 2).
    for (int i = 0; i < 4; i++) apply(1'b0, 4'b0001, '0);
    apply(1'b1, 4'b0001, '0);
    check("mid_reset", 16'({led, pp, rp}), 16'h0);
    k_hit = -1;
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, 4'b0001, '0);
      if (pp[0] && k_hit < 0) k_hit = k;
    end
    check("post_reset_latency", 16'(k_hit), 16'd5);
    for (int i = 0; i < 8; i++) apply(1'b0, 4'b0000, '0);

    // Randomised traffic against the reference model.
    rb = '0; rm = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
      if ($urandom_range(0, 99) == 0) rm = 4'($urandom);
      rr = ($urandom_range(0, 399) == 0);
      apply(rr, rb, rm);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
